// File: rtl/qbus_master.sv
// qbus_master: Q-bus master cycle sequencer (DATI, DATO, DATIO, IAK).
// Ports: pin_clk/pin_rst; req_*/wr_stb in; busy/rsp_* out; pin_* Q-bus side.
module qbus_master #(
   parameter int ADDR_W = 22,
   parameter int TOUT_W = 6,
   parameter int SETUP  = 1
) (
   input  logic              pin_clk,
   input  logic              pin_rst,
   input  logic              req_stb,
   input  logic [1:0]        req_op,
   input  logic              req_byte,
   input  logic [ADDR_W-1:0] req_adr,
   input  logic [15:0]       req_dat,
   input  logic              wr_stb,
   output logic              busy,
   output logic              rsp_rdy,
   output logic              rsp_err,
   output logic [15:0]       rsp_dat,
   output logic [15:0]       pin_ad_o,
   output logic              pin_ad_oe,
   output logic [((ADDR_W > 16) ? ADDR_W - 16 : 1)-1:0] pin_a_o,
   output logic              pin_bs,
   output logic              pin_sync,
   output logic              pin_din,
   output logic              pin_dout,
   output logic              pin_iako,
   output logic              pin_wtbt,
   input  logic              pin_rply,
   input  logic [15:0]       pin_ad_i
);

   localparam int AH_W = (ADDR_W > 16) ? ADDR_W - 16 : 1;
   localparam logic [2:0] SET_LAST = 3'(SETUP - 1);

   localparam logic [1:0] OP_DATI  = 2'b00;
   localparam logic [1:0] OP_DATO  = 2'b01;
   localparam logic [1:0] OP_DATIO = 2'b10;
   localparam logic [1:0] OP_IAK   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADR,
      S_SYN,
      S_STB,
      S_RPL,
      S_WWT,
      S_END
   } state_t;

   state_t state;
   state_t state_n;

   logic [ADDR_W-1:0] adr_q;
   logic [1:0]        op_q;
   logic              byte_q;
   logic [15:0]       dat_q;
   logic              wr_ph;
   logic [2:0]        set_cnt;
   logic [TOUT_W-1:0] tout_cnt;

   logic            take_req;
   logic            take_wr;
   logic            lat_rd;
   logic            rdy_n;
   logic            err_n;
   logic            adr_drv;
   logic            is_iak;
   logic            is_wr;
   logic            is_dato;
   logic            bank7;
   logic [AH_W-1:0] adr_hi;

   assign is_iak  = (op_q == OP_IAK);
   assign is_dato = (op_q == OP_DATO);
   // DATIO switches to its write half once wr_stb has been taken
   assign is_wr   = is_dato || ((op_q == OP_DATIO) && wr_ph);
   assign bank7   = &adr_q[ADDR_W-1:13];
   assign busy    = (state != S_IDLE);

   generate
      if (ADDR_W > 16) begin : g_hi
         assign adr_hi = adr_q[ADDR_W-1:16];
      end else begin : g_nohi
         assign adr_hi = '0;
      end
   endgenerate

   assign pin_a_o = adr_drv ? adr_hi : '0;
   assign pin_bs  = adr_drv & bank7;

   always_ff @(posedge pin_clk) begin
      if (pin_rst) begin
         state    <= S_IDLE;
         adr_q    <= '0;
         op_q     <= OP_DATI;
         byte_q   <= 1'b0;
         dat_q    <= '0;
         wr_ph    <= 1'b0;
         set_cnt  <= '0;
         tout_cnt <= '0;
         rsp_rdy  <= 1'b0;
         rsp_err  <= 1'b0;
         rsp_dat  <= '0;
      end else begin
         state   <= state_n;
         rsp_rdy <= rdy_n;
         rsp_err <= err_n;
         set_cnt <= (state == S_ADR) ? set_cnt + 3'd1 : 3'd0;
         // free-running in STB, so it wraps rather than saturates
         tout_cnt <= (state == S_STB) ? tout_cnt + TOUT_W'(1) : '0;
         if (take_req) begin
            adr_q  <= req_adr;
            op_q   <= req_op;
            byte_q <= req_byte;
            dat_q  <= req_dat;
            wr_ph  <= 1'b0;
         end
         if (take_wr) begin
            dat_q  <= req_dat;
            byte_q <= req_byte;
            wr_ph  <= 1'b1;
         end
         if (lat_rd) begin
            rsp_dat <= pin_ad_i;
         end
      end
   end

   always_comb begin
      state_n   = state;
      take_req  = 1'b0;
      take_wr   = 1'b0;
      lat_rd    = 1'b0;
      rdy_n     = 1'b0;
      err_n     = 1'b0;
      adr_drv   = 1'b0;
      pin_ad_oe = 1'b0;
      pin_ad_o  = '0;
      pin_sync  = 1'b0;
      pin_din   = 1'b0;
      pin_dout  = 1'b0;
      pin_iako  = 1'b0;
      pin_wtbt  = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (req_stb) begin
               take_req = 1'b1;
               state_n  = (req_op == OP_IAK) ? S_SYN : S_ADR;
            end
         end
         S_ADR: begin
            adr_drv  = 1'b1;
            pin_wtbt = is_dato;
            if (set_cnt == SET_LAST) begin
               state_n = S_SYN;
            end
         end
         S_SYN: begin
            // IAK carries no address and never raises SYNC
            adr_drv  = !is_iak;
            pin_sync = !is_iak;
            pin_wtbt = is_dato;
            state_n  = S_STB;
         end
         S_STB: begin
            pin_sync = !is_iak;
            pin_iako = is_iak;
            if (is_wr) begin
               pin_dout  = 1'b1;
               pin_ad_oe = 1'b1;
               pin_ad_o  = dat_q;
               pin_wtbt  = byte_q;
            end else begin
               pin_din = 1'b1;
            end
            // a reply on the wrap edge still completes normally
            if (pin_rply) begin
               lat_rd  = !is_wr;
               state_n = S_RPL;
            end else if (&tout_cnt) begin
               err_n   = 1'b1;
               state_n = S_END;
            end
         end
         S_RPL: begin
            pin_sync = !is_iak;
            if (!pin_rply) begin
               rdy_n = 1'b1;
               if ((op_q == OP_DATIO) && !wr_ph) begin
                  if (wr_stb) begin
                     take_wr = 1'b1;
                     state_n = S_STB;
                  end else begin
                     state_n = S_WWT;
                  end
               end else begin
                  state_n = S_END;
               end
            end
         end
         S_WWT: begin
            pin_sync = 1'b1;
            if (wr_stb) begin
               take_wr = 1'b1;
               state_n = S_STB;
            end
         end
         S_END: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      if (adr_drv) begin
         pin_ad_oe = 1'b1;
         pin_ad_o  = adr_q[15:0];
      end
   end

endmodule

// File: tb/tb_qbus_master.sv
// tb_qbus_master: directed + random transactions against a cycle-count model.
// Drives qbus_master with SETUP=1, TOUT_W=3 and a scripted reply slave.
module tb_qbus_master;

   localparam int SETUP  = 1;
   localparam int TOUT_W = 3;
   localparam int TO     = 8;

   logic        pin_clk = 1'b0;
   logic        pin_rst;
   logic        req_stb;
   logic [1:0]  req_op;
   logic        req_byte;
   logic [21:0] req_adr;
   logic [15:0] req_dat;
   logic        wr_stb;
   logic        busy;
   logic        rsp_rdy;
   logic        rsp_err;
   logic [15:0] rsp_dat;
   logic [15:0] pin_ad_o;
   logic        pin_ad_oe;
   logic [5:0]  pin_a_o;
   logic        pin_bs;
   logic        pin_sync;
   logic        pin_din;
   logic        pin_dout;
   logic        pin_iako;
   logic        pin_wtbt;
   logic        pin_rply;
   logic [15:0] pin_ad_i;

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_rsp_dat = 16'h0;

   always #5 pin_clk = ~pin_clk;

   qbus_master #(
      .ADDR_W(22),
      .TOUT_W(TOUT_W),
      .SETUP (SETUP)
   ) dut (
      .pin_clk  (pin_clk),
      .pin_rst  (pin_rst),
      .req_stb  (req_stb),
      .req_op   (req_op),
      .req_byte (req_byte),
      .req_adr  (req_adr),
      .req_dat  (req_dat),
      .wr_stb   (wr_stb),
      .busy     (busy),
      .rsp_rdy  (rsp_rdy),
      .rsp_err  (rsp_err),
      .rsp_dat  (rsp_dat),
      .pin_ad_o (pin_ad_o),
      .pin_ad_oe(pin_ad_oe),
      .pin_a_o  (pin_a_o),
      .pin_bs   (pin_bs),
      .pin_sync (pin_sync),
      .pin_din  (pin_din),
      .pin_dout (pin_dout),
      .pin_iako (pin_iako),
      .pin_wtbt (pin_wtbt),
      .pin_rply (pin_rply),
      .pin_ad_i (pin_ad_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // d = strobe cycles before reply (>=TO: no reply), h = extra reply cycles,
   // wd = DATIO write-strobe delay after rsp_rdy (-1: together with reply drop)
   task automatic run_txn(
      input string nm, input logic [1:0] op, input logic [21:0] adr,
      input logic [15:0] dat, input logic byt, input logic [15:0] rdat,
      input int d1, input int h1, input int wd,
      input logic [15:0] wdat, input logic wbyt, input int d2, input int h2);
      int cyc, busy_len, str_cnt, hold_cnt, phase, wr_at, cd, ch;
      int n_sync, sync_first, n_din, n_dout, n_iako, n_rdy, n_err;
      int rdy_first, str_first, bad_adr, bad_wr, bad_prot;
      int start1, end1, ws, e_len, c1, c2, e_rdy, e_err, e_rdy_first;
      logic done, iak, datio, rd1, e_bs;
      logic [15:0] cw;
      logic cb;

      iak   = (op == 2'b11);
      datio = (op == 2'b10);
      rd1   = (op != 2'b01);
      e_bs  = &adr[21:13];

      // reference: cycle numbers counted from the accepting edge
      start1 = iak ? 2 : SETUP + 2;
      end1 = 0; c1 = 0; c2 = 0; e_rdy = 0; e_err = 0;
      if (d1 >= TO) begin
         c1 = TO; e_err = 1; e_len = start1 + TO;
      end else begin
         c1 = d1 + 1;
         end1 = start1 + d1 + h1 + 2;
         e_rdy = 1;
         if (rd1) exp_rsp_dat = rdat;
         if (!datio) begin
            e_len = end1;
         end else begin
            ws = end1 + wd + 1;
            if (d2 >= TO) begin
               c2 = TO; e_err = 1; e_len = ws + TO;
            end else begin
               c2 = d2 + 1; e_rdy = 2; e_len = ws + d2 + h2 + 2;
            end
         end
      end
      e_rdy_first = (d1 >= TO) ? 0 : end1;

      req_stb = 1'b1; req_op = op; req_adr = adr;
      req_dat = dat; req_byte = byt;
      @(posedge pin_clk);

      busy_len = 0; str_cnt = 0; hold_cnt = 0; phase = 0; wr_at = -100;
      n_sync = 0; sync_first = 0; n_din = 0; n_dout = 0; n_iako = 0;
      n_rdy = 0; n_err = 0; rdy_first = 0; str_first = 0;
      bad_adr = 0; bad_wr = 0; bad_prot = 0; done = 1'b0;
      cw = (op == 2'b01) ? dat : wdat;
      cb = (op == 2'b01) ? byt : wbyt;

      for (cyc = 1; cyc <= 200 && !done; cyc++) begin
         @(negedge pin_clk);
         wr_stb = 1'b0;
         if (cyc == 1) req_stb = 1'b0;
         if (cyc == 3) begin
            req_stb = 1'b1; req_adr = ~adr; req_op = ~op;
         end
         if (cyc == 4) req_stb = 1'b0;
         if (!busy) begin
            done = 1'b1;
         end else begin
            busy_len = cyc;
            cd = (phase == 1) ? d2 : d1;
            ch = (phase == 1) ? h2 : h1;
            if (pin_sync) begin
               n_sync++;
               if (sync_first == 0) sync_first = cyc;
            end
            if (pin_din)  n_din++;
            if (pin_dout) n_dout++;
            if (pin_iako) n_iako++;
            if (pin_din && pin_dout)  bad_prot++;
            if (pin_din && pin_ad_oe) bad_prot++;
            if (rsp_err) n_err++;
            if (rsp_rdy) begin
               n_rdy++;
               if (rdy_first == 0) rdy_first = cyc;
               if (datio && phase == 0) wr_at = cyc + wd;
            end
            if (!iak && cyc <= SETUP) begin
               if (!(pin_ad_oe && pin_ad_o == adr[15:0] &&
                     pin_a_o == adr[21:16] && pin_bs == e_bs &&
                     pin_wtbt == (op == 2'b01) && !pin_sync &&
                     !pin_din && !pin_dout))
                  bad_adr++;
            end
            if (pin_dout) begin
               if (!(pin_ad_oe && pin_ad_o == cw && pin_wtbt == cb))
                  bad_wr++;
            end
            if (cyc == wr_at) begin
               wr_stb = 1'b1; req_dat = wdat; req_byte = wbyt; phase = 1;
            end
            if (pin_din || pin_dout) begin
               if (str_first == 0) str_first = cyc;
               str_cnt++;
               if (str_cnt == cd + 1) begin
                  pin_rply = 1'b1;
                  pin_ad_i = (phase == 0) ? rdat : 16'($urandom);
               end
            end else if (pin_rply) begin
               hold_cnt++;
               if (hold_cnt == ch + 1) begin
                  pin_rply = 1'b0;
                  pin_ad_i = 16'($urandom);
                  str_cnt = 0; hold_cnt = 0;
                  if (datio && phase == 0 && wd < 0) begin
                     wr_stb = 1'b1; req_dat = wdat;
                     req_byte = wbyt; phase = 1;
                  end
               end
            end else begin
               str_cnt = 0;
            end
         end
      end
      pin_rply = 1'b0;
      wr_stb   = 1'b0;

      chk({nm, ":idle"}, 32'(done), 32'd1);
      chk({nm, ":len"}, busy_len, e_len);
      chk({nm, ":sync_n"}, n_sync, iak ? 0 : e_len - SETUP - 1);
      chk({nm, ":sync_at"}, sync_first, iak ? 0 : SETUP + 1);
      chk({nm, ":str_at"}, str_first, start1);
      chk({nm, ":din"}, n_din, rd1 ? c1 : 0);
      chk({nm, ":dout"}, n_dout, rd1 ? c2 : c1);
      chk({nm, ":iako"}, n_iako, iak ? c1 : 0);
      chk({nm, ":rdy"}, n_rdy, e_rdy);
      chk({nm, ":rdy_at"}, rdy_first, e_rdy_first);
      chk({nm, ":err"}, n_err, e_err);
      chk({nm, ":rsp_dat"}, 32'(rsp_dat), 32'(exp_rsp_dat));
      chk({nm, ":prot"}, bad_prot, 0);
      chk({nm, ":adr"}, bad_adr, 0);
      chk({nm, ":wdat"}, bad_wr, 0);
   endtask

   initial begin
      int k;
      logic seen;
      pin_rst = 1'b1; req_stb = 1'b0; req_op = 2'b00; req_byte = 1'b0;
      req_adr = '0; req_dat = '0; wr_stb = 1'b0;
      pin_rply = 1'b0; pin_ad_i = '0;
      repeat (2) @(posedge pin_clk);
      @(negedge pin_clk);
      chk("reset:outs", {busy, rsp_rdy, rsp_err, pin_ad_oe, pin_sync,
          pin_din, pin_dout, pin_iako, pin_wtbt, pin_bs, pin_a_o,
          pin_ad_o}, 32'd0);
      chk("reset:rsp_dat", 32'(rsp_dat), 32'd0);
      pin_rst = 1'b0;

      run_txn("dati", 2'b00, 22'o157776, 16'h0, 1'b0, 16'o012345,
              2, 0, 0, 16'h0, 1'b0, 0, 0);
      run_txn("dato_byte", 2'b01, 22'o17777566, 16'h00A5, 1'b1, 16'h0,
              1, 1, 0, 16'h0, 1'b0, 0, 0);
      run_txn("datio", 2'b10, 22'o001000, 16'h0, 1'b0, 16'h1234,
              1, 0, 3, 16'h4321, 1'b0, 0, 1);
      run_txn("datio_rpl_wr", 2'b10, 22'o002000, 16'h0, 1'b0, 16'h5A5A,
              0, 1, -1, 16'h00C3, 1'b1, 2, 0);
      run_txn("tout", 2'b00, 22'o003000, 16'h0, 1'b0, 16'hBEEF,
              20, 0, 0, 16'h0, 1'b0, 0, 0);
      run_txn("tout_edge", 2'b00, 22'o003002, 16'h0, 1'b0, 16'hCAFE,
              7, 0, 0, 16'h0, 1'b0, 0, 0);
      run_txn("tout_dato", 2'b01, 22'o003004, 16'h7777, 1'b0, 16'h0,
              20, 0, 0, 16'h0, 1'b0, 0, 0);
      run_txn("iak", 2'b11, 22'o0, 16'h0, 1'b0, 16'o000060,
              0, 0, 0, 16'h0, 1'b0, 0, 0);

      // reset while DOUT is asserted
      req_stb = 1'b1; req_op = 2'b01; req_adr = 22'o004000;
      req_dat = 16'h1111; req_byte = 1'b0;
      @(posedge pin_clk);
      seen = 1'b0;
      for (k = 0; k < 20 && !seen; k++) begin
         @(negedge pin_clk);
         req_stb = 1'b0;
         if (pin_dout) seen = 1'b1;
      end
      chk("rst_mid:dout_seen", 32'(seen), 32'd1);
      pin_rst = 1'b1;
      @(posedge pin_clk);
      @(negedge pin_clk);
      chk("rst_mid:outs", {busy, rsp_rdy, rsp_err, pin_ad_oe, pin_sync,
          pin_din, pin_dout, pin_iako, pin_wtbt, pin_bs, pin_a_o,
          pin_ad_o}, 32'd0);
      pin_rst = 1'b0;
      exp_rsp_dat = 16'h0;
      run_txn("after_rst", 2'b00, 22'o005000, 16'h0, 1'b0, 16'h2468,
              0, 0, 0, 16'h0, 1'b0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         logic [1:0]  op;
         logic [21:0] adr;
         int d1, h1, wd, d2, h2;
         op  = 2'($urandom_range(0, 3));
         adr = 22'($urandom);
         if ($urandom_range(0, 3) == 0) adr[21:13] = '1;
         d1 = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 7));
         d2 = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 7));
         h1 = int'($urandom_range(0, 3));
         h2 = int'($urandom_range(0, 3));
         wd = int'($urandom_range(0, 4)) - 1;
         run_txn($sformatf("rnd%0d", i), op, adr, 16'($urandom),
                 1'($urandom), 16'($urandom), d1, h1, wd,
                 16'($urandom), 1'($urandom), d2, h2);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
